// File: rtl/inert_spi_resp_if.sv
// SPI pin bundle between the 16-bit SPI master and the inertial sensor model.
interface inert_spi_resp_if;
   logic SS_n;
   logic SCLK;
   logic MOSI;
   logic MISO;

   modport master (output SS_n, output SCLK, output MOSI, input MISO);
   modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/inert_spi_resp.sv
// Inertial sensor SPI responder: 16-bit read/write frames, configuration
// registers, ten polled data bytes and a data-ready interrupt.
module inert_spi_resp #(
   parameter int unsigned SCLK_DIV_MIN = 8,
   parameter logic [7:0]  WHO_AM_I     = 8'h6A
) (
   input  logic            clk,
   input  logic            rst,
   inert_spi_resp_if.slave spi,
   output logic            INT,
   input  logic            smpl_vld,
   input  logic [15:0]     ptch_in,
   input  logic [15:0]     roll_in,
   input  logic [15:0]     yaw_in,
   input  logic [15:0]     ax_in,
   input  logic [15:0]     ay_in,
   output logic [7:0]      cfg_int1,
   output logic [7:0]      cfg_xl,
   output logic [7:0]      cfg_g,
   output logic [7:0]      cfg_ctrl3
);

   localparam logic [7:0] HALF_MIN = 8'(SCLK_DIV_MIN / 2);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, CMPL} state_t;

   typedef struct packed {
      logic [15:0] ptch;
      logic [15:0] roll;
      logic [15:0] yaw;
      logic [15:0] ax;
      logic [15:0] ay;
   } smpl_t;

   state_t      state, state_nxt;
   logic [2:0]  ss_sync;
   logic [2:0]  sclk_sync;
   logic [1:0]  mosi_sync;
   logic        mosi_s;
   logic        ss_fall, ss_rise;
   logic        sclk_rise_raw, sclk_fall_raw;
   logic        sclk_rise, sclk_fall;
   logic        edge_ok;
   logic [7:0]  gap_cnt;
   logic [3:0]  bit_cnt;
   logic [15:0] cmd, cmd_nxt;
   logic [7:0]  miso_sr;
   logic        miso_q;
   logic [7:0]  rd_data;
   logic [6:0]  rd_addr;
   logic        shift_en, cnt_clr, load_miso, commit;
   logic        apply, int_clr;
   smpl_t       smpl_new, smpl_q, pend_q, smpl_src;
   logic        pend_vld;

   assign spi.MISO = miso_q;

   // Bring the asynchronous SPI pins into the clk domain; third stage gives edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         // Reset low so an SS_n already low mid-frame never looks like a fresh fall.
         ss_sync   <= '0;
         sclk_sync <= '0;
         mosi_sync <= '0;
      end else begin
         ss_sync   <= {ss_sync[1:0], spi.SS_n};
         sclk_sync <= {sclk_sync[1:0], spi.SCLK};
         mosi_sync <= {mosi_sync[0], spi.MOSI};
      end
   end

   assign mosi_s        = mosi_sync[1];
   assign ss_fall       = ss_sync[2] & ~ss_sync[1];
   assign ss_rise       = ~ss_sync[2] & ss_sync[1];
   assign sclk_rise_raw = ~sclk_sync[2] & sclk_sync[1];
   assign sclk_fall_raw = sclk_sync[2] & ~sclk_sync[1];

   // SCLK edges closer together than the minimum half period are treated as glitches.
   assign edge_ok   = (gap_cnt >= HALF_MIN);
   assign sclk_rise = sclk_rise_raw & edge_ok;
   assign sclk_fall = sclk_fall_raw & edge_ok;

   // Saturating count of clk cycles since the last accepted SCLK edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         gap_cnt <= '1;
      end else if (sclk_rise | sclk_fall) begin
         gap_cnt <= '0;
      end else if (gap_cnt != '1) begin
         gap_cnt <= gap_cnt + 8'd1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and frame-control strobes.
   always_comb begin
      state_nxt = state;
      shift_en  = 1'b0;
      cnt_clr   = 1'b0;
      load_miso = 1'b0;
      commit    = 1'b0;
      unique case (state)
         IDLE: begin
            if (ss_fall) begin
               state_nxt = ADDR;
               cnt_clr   = 1'b1;
            end
         end
         ADDR: begin
            if (sclk_rise) begin
               shift_en = 1'b1;
               if (bit_cnt == 4'd7) begin
                  state_nxt = DATA;
                  load_miso = 1'b1;
               end
            end
         end
         DATA: begin
            if (sclk_rise) begin
               shift_en = 1'b1;
               if (bit_cnt == 4'd15) begin
                  state_nxt = CMPL;
               end
            end
         end
         CMPL: begin
            commit    = 1'b1;
            state_nxt = IDLE;
         end
      endcase
      // A completed frame still commits in CMPL even if SS_n rises that cycle.
      if (ss_rise) begin
         state_nxt = IDLE;
         cnt_clr   = 1'b1;
         shift_en  = 1'b0;
         load_miso = 1'b0;
      end
   end

   assign cmd_nxt = {cmd[14:0], mosi_s};
   assign rd_addr = cmd_nxt[6:0];

   // Bit counter and command shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= '0;
         cmd     <= '0;
      end else begin
         if (cnt_clr) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + 4'd1;
         end
         if (shift_en) begin
            cmd <= cmd_nxt;
         end
      end
   end

   // Read map, decoded from the address completing on the 8th rise.
   always_comb begin
      rd_data = 8'h00;
      unique case (rd_addr)
         7'h0D:   rd_data = cfg_int1;
         7'h0F:   rd_data = WHO_AM_I;
         7'h10:   rd_data = cfg_xl;
         7'h11:   rd_data = cfg_g;
         7'h14:   rd_data = cfg_ctrl3;
         7'h22:   rd_data = smpl_q.ptch[7:0];
         7'h23:   rd_data = smpl_q.ptch[15:8];
         7'h24:   rd_data = smpl_q.roll[7:0];
         7'h25:   rd_data = smpl_q.roll[15:8];
         7'h26:   rd_data = smpl_q.yaw[7:0];
         7'h27:   rd_data = smpl_q.yaw[15:8];
         7'h28:   rd_data = smpl_q.ax[7:0];
         7'h29:   rd_data = smpl_q.ax[15:8];
         7'h2A:   rd_data = smpl_q.ay[7:0];
         7'h2B:   rd_data = smpl_q.ay[15:8];
         default: rd_data = 8'h00;
      endcase
   end

   // MISO shift register: loaded at ADDR->DATA, one bit out per SCLK fall in DATA.
   always_ff @(posedge clk) begin
      if (rst) begin
         miso_sr <= '0;
         miso_q  <= 1'b0;
      end else begin
         if (load_miso) begin
            miso_sr <= cmd_nxt[7] ? rd_data : 8'h00;
         end else if ((state == DATA) && sclk_fall) begin
            miso_sr <= {miso_sr[6:0], 1'b0};
         end
         if (state != DATA) begin
            miso_q <= 1'b0;
         end else if (sclk_fall) begin
            miso_q <= miso_sr[7];
         end
      end
   end

   // Configuration register writes on completed write frames.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_int1  <= '0;
         cfg_xl    <= '0;
         cfg_g     <= '0;
         cfg_ctrl3 <= '0;
      end else if (commit && !cmd[15]) begin
         unique case (cmd[14:8])
            7'h0D:   cfg_int1  <= cmd[7:0];
            7'h10:   cfg_xl    <= cmd[7:0];
            7'h11:   cfg_g     <= cmd[7:0];
            7'h14:   cfg_ctrl3 <= cmd[7:0];
            default: ;
         endcase
      end
   end

   assign smpl_new = '{ptch: ptch_in, roll: roll_in, yaw: yaw_in, ax: ax_in, ay: ay_in};
   // Samples only land in IDLE so no frame ever mixes old and new bytes;
   // a fresh strobe beats a pending one.
   assign apply    = (state == IDLE) && (smpl_vld || pend_vld);
   assign smpl_src = smpl_vld ? smpl_new : pend_q;

   // Pending buffer for samples arriving mid-frame, and the live data registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q   <= '0;
         pend_vld <= 1'b0;
         smpl_q   <= '0;
      end else begin
         if (smpl_vld && (state != IDLE)) begin
            pend_q   <= smpl_new;
            pend_vld <= 1'b1;
         end else if (apply) begin
            pend_vld <= 1'b0;
         end
         if (apply) begin
            smpl_q <= smpl_src;
         end
      end
   end

   assign int_clr = commit && cmd[15] && (cmd[14:8] == 7'h22);

   // Data-ready interrupt: set on sample apply (when enabled) wins over clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         INT <= 1'b0;
      end else if (apply && cfg_int1[1]) begin
         INT <= 1'b1;
      end else if (int_clr) begin
         INT <= 1'b0;
      end
   end

endmodule

// File: tb/tb_inert_spi_resp.sv
// Directed bench for the inertial sensor SPI responder.
module tb_inert_spi_resp;

   localparam int H = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        smpl_vld = 1'b0;
   logic [15:0] ptch = '0, roll = '0, yaw = '0, ax = '0, ay = '0;
   logic [7:0]  cfg_int1, cfg_xl, cfg_g, cfg_ctrl3;
   logic        irq;
   int          n_cmp = 0;
   int          n_err = 0;

   inert_spi_resp_if bus ();

   inert_spi_resp #(.SCLK_DIV_MIN(8), .WHO_AM_I(8'h6A)) dut (
      .clk       (clk),
      .rst       (rst),
      .spi       (bus),
      .INT       (irq),
      .smpl_vld  (smpl_vld),
      .ptch_in   (ptch),
      .roll_in   (roll),
      .yaw_in    (yaw),
      .ax_in     (ax),
      .ay_in     (ay),
      .cfg_int1  (cfg_int1),
      .cfg_xl    (cfg_xl),
      .cfg_g     (cfg_g),
      .cfg_ctrl3 (cfg_ctrl3)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_start();
      bus.SS_n = 1'b0;
      wait_clk(H);
   endtask

   task automatic spi_bit(input logic b, output logic m);
      bus.MOSI = b;
      wait_clk(H);
      bus.SCLK = 1'b1;
      m = bus.MISO;
      wait_clk(H);
      bus.SCLK = 1'b0;
   endtask

   task automatic spi_stop();
      wait_clk(H);
      bus.SS_n = 1'b1;
      wait_clk(8);
   endtask

   task automatic pulse_smpl();
      smpl_vld = 1'b1;
      wait_clk(1);
      smpl_vld = 1'b0;
   endtask

   // Full or truncated frame; smpl_at >= 0 pulses smpl_vld before that bit.
   task automatic spi_xfer(input logic [15:0] tx, input int nbits, input int smpl_at,
                           output logic [15:0] rx);
      logic m;
      rx = '0;
      spi_start();
      for (int i = 0; i < nbits; i++) begin
         if (i == smpl_at) pulse_smpl();
         spi_bit(tx[15-i], m);
         rx[15-i] = m;
      end
      spi_stop();
   endtask

   task automatic test_reset();
      bus.SS_n = 1'b1;
      bus.SCLK = 1'b0;
      bus.MOSI = 1'b0;
      rst = 1'b1;
      wait_clk(4);
      n_cmp++;
      if (bus.MISO !== 1'b0) begin
         n_err++; $display("FAIL reset_miso: got %b want 0", bus.MISO);
      end
      n_cmp++;
      if (irq !== 1'b0) begin
         n_err++; $display("FAIL reset_int: got %b want 0", irq);
      end
      n_cmp++;
      if ({cfg_int1, cfg_xl, cfg_g, cfg_ctrl3} !== 32'h0) begin
         n_err++; $display("FAIL reset_cfg: got %h want 00000000",
                           {cfg_int1, cfg_xl, cfg_g, cfg_ctrl3});
      end
      rst = 1'b0;
      wait_clk(4);
   endtask

   task automatic test_startup();
      logic [15:0] rx;
      spi_xfer(16'h0D02, 16, -1, rx);
      spi_xfer(16'h1062, 16, -1, rx);
      spi_xfer(16'h1162, 16, -1, rx);
      spi_xfer(16'h1460, 16, -1, rx);
      n_cmp++;
      if ({cfg_int1, cfg_xl, cfg_g, cfg_ctrl3} !== 32'h02626260) begin
         n_err++; $display("FAIL startup_cfg: got %h want 02626260",
                           {cfg_int1, cfg_xl, cfg_g, cfg_ctrl3});
      end
      n_cmp++;
      if (irq !== 1'b0) begin
         n_err++; $display("FAIL startup_int: got %b want 0", irq);
      end
   endtask

   task automatic test_identity();
      logic [15:0] rx;
      spi_xfer(16'h8F00, 16, -1, rx);
      n_cmp++;
      if (rx !== 16'h006A) begin
         n_err++; $display("FAIL identity_read: got %h want 006a", rx);
      end
      // Write to a read-only address must not disturb anything.
      spi_xfer(16'h0F55, 16, -1, rx);
      spi_xfer(16'h8F00, 16, -1, rx);
      n_cmp++;
      if (rx !== 16'h006A) begin
         n_err++; $display("FAIL identity_after_write: got %h want 006a", rx);
      end
   endtask

   task automatic test_full_poll();
      logic [15:0] rx;
      logic [7:0]  exp_b [10];
      exp_b = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h0F, 8'h0F, 8'h01, 8'h80, 8'hFE, 8'h7F};
      ptch = 16'h1234; roll = 16'hABCD; yaw = 16'h0F0F; ax = 16'h8001; ay = 16'h7FFE;
      n_cmp++;
      if (irq !== 1'b0) begin
         n_err++; $display("FAIL poll_int_before: got %b want 0", irq);
      end
      smpl_vld = 1'b1;
      wait_clk(1);
      smpl_vld = 1'b0;
      n_cmp++;
      if (irq !== 1'b1) begin
         n_err++; $display("FAIL poll_int_rise: got %b want 1", irq);
      end
      for (int i = 0; i < 10; i++) begin
         spi_xfer({8'hA2 + 8'(i), 8'h00}, 16, -1, rx);
         n_cmp++;
         if (rx !== {8'h00, exp_b[i]}) begin
            n_err++; $display("FAIL poll_read_%0d: got %h want %h", i, rx, {8'h00, exp_b[i]});
         end
         if (i == 0) begin
            n_cmp++;
            if (irq !== 1'b0) begin
               n_err++; $display("FAIL poll_int_clear: got %b want 0", irq);
            end
         end
      end
   endtask

   task automatic test_sample_during_frame();
      logic [15:0] rx;
      ptch = 16'h5555;
      spi_xfer(16'hA300, 16, 11, rx);
      n_cmp++;
      if (rx !== 16'h0012) begin
         n_err++; $display("FAIL midframe_old: got %h want 0012", rx);
      end
      n_cmp++;
      if (irq !== 1'b1) begin
         n_err++; $display("FAIL midframe_int: got %b want 1", irq);
      end
      spi_xfer(16'hA300, 16, -1, rx);
      n_cmp++;
      if (rx !== 16'h0055) begin
         n_err++; $display("FAIL midframe_new: got %h want 0055", rx);
      end
   endtask

   task automatic test_abort();
      logic [15:0] rx;
      spi_xfer(16'h10FF, 10, -1, rx);
      n_cmp++;
      if (cfg_xl !== 8'h62) begin
         n_err++; $display("FAIL abort_cfg_xl: got %h want 62", cfg_xl);
      end
      spi_xfer(16'h9000, 16, -1, rx);
      n_cmp++;
      if (rx !== 16'h0062) begin
         n_err++; $display("FAIL abort_next_frame: got %h want 0062", rx);
      end
   endtask

   task automatic test_priority();
      logic [15:0] rx;
      ptch = 16'h5566;
      spi_xfer(16'hA200, 16, 13, rx);
      n_cmp++;
      if (rx !== 16'h0055) begin
         n_err++; $display("FAIL prio_read: got %h want 0055", rx);
      end
      n_cmp++;
      if (irq !== 1'b1) begin
         n_err++; $display("FAIL prio_int_kept: got %b want 1", irq);
      end
      spi_xfer(16'hA200, 16, -1, rx);
      n_cmp++;
      if (rx !== 16'h0066) begin
         n_err++; $display("FAIL prio_read_new: got %h want 0066", rx);
      end
      n_cmp++;
      if (irq !== 1'b0) begin
         n_err++; $display("FAIL prio_int_clear: got %b want 0", irq);
      end
      pulse_smpl();
      n_cmp++;
      if (irq !== 1'b1) begin
         n_err++; $display("FAIL prio_int_reset_pre: got %b want 1", irq);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] tx;
      logic [15:0] rx;
      logic        m;
      tx = 16'h8F00;
      spi_start();
      for (int i = 0; i < 10; i++) spi_bit(tx[15-i], m);
      wait_clk(4);
      n_cmp++;
      if (bus.MISO !== 1'b1) begin
         n_err++; $display("FAIL midreset_pre_miso: got %b want 1", bus.MISO);
      end
      rst = 1'b1;
      wait_clk(1);
      n_cmp++;
      if (bus.MISO !== 1'b0) begin
         n_err++; $display("FAIL midreset_miso: got %b want 0", bus.MISO);
      end
      n_cmp++;
      if (irq !== 1'b0) begin
         n_err++; $display("FAIL midreset_int: got %b want 0", irq);
      end
      rst = 1'b0;
      for (int i = 10; i < 16; i++) begin
         spi_bit(tx[15-i], m);
         n_cmp++;
         if (m !== 1'b0) begin
            n_err++; $display("FAIL midreset_tail_bit%0d: got %b want 0", i, m);
         end
      end
      spi_stop();
      n_cmp++;
      if (cfg_int1 !== 8'h00) begin
         n_err++; $display("FAIL midreset_cfg: got %h want 00", cfg_int1);
      end
      spi_xfer(16'h0D02, 16, -1, rx);
      spi_xfer(16'h8D00, 16, -1, rx);
      n_cmp++;
      if (rx !== 16'h0002) begin
         n_err++; $display("FAIL midreset_recover: got %h want 0002", rx);
      end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_identity();
      test_full_poll();
      test_sample_during_frame();
      test_abort();
      test_priority();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/inert_spi_resp.md
# inert_spi_resp

SPI responder modelling the inertial sensor on the other end of the 16-bit SPI master link. It decodes 16-bit read/write frames and holds the configuration registers the master writes at start-up. It serves the ten gyro/accel data bytes the master polls after each interrupt, and raises `INT` when a new sample is loaded. It is used as the sensor model in full-chip benches and as an FPGA loop-back target.

## Interface
- `SCLK_DIV_MIN`, default 8: minimum number of `clk` periods per SCLK period supported.
- `WHO_AM_I`, default 8'h6A: value returned for reads of address 0x0F.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `SS_n`  in  1  slave select, active low, asynchronous to `clk`.
- `SCLK`  in  1  SPI clock, mode 0 (idles low), asynchronous to `clk`.
- `MOSI`  in  1  command/data from the master, MSB first.
- `MISO`  out  1  read data to the master, MSB first.
- `INT`  out  1  data-ready interrupt, active high.
- `smpl_vld`  in  1  one-cycle strobe: load a new sample from the five inputs below.
- `ptch_in`, `roll_in`, `yaw_in`, `ax_in`, `ay_in`  in  16 each  new sample values.
- `cfg_int1`, `cfg_xl`, `cfg_g`, `cfg_ctrl3`  out  8 each  registers 0x0D, 0x10, 0x11, 0x14.

## Operation
- `SS_n`, `SCLK` and `MOSI` are each passed through two flops. Edge detect uses a third flop. `SCLK` rise and fall events and `SS_n` fall and rise events are one-cycle pulses.
- Frame format: bit15 selects read (1) or write (0). Bits 14:8 are the address. Bits 7:0 are write data; the master sends don't-care bits during a read.
- FSM states and transitions:
  - IDLE: wait for an `SS_n` fall.
  - ADDR: count 8 SCLK rises, shifting MOSI into the command register.
  - DATA: count 8 more rises.
  - CMPL: one cycle, then return to IDLE.
- In every state, an `SS_n` rise forces IDLE and clears the bit counter. A frame shorter than 16 bits is discarded with no register write and no INT clear.
- ADDR→DATA occurs on the 8th rise. If bit15 = 1, the read byte for the address is loaded into the MISO shift register on that cycle.
- MISO output rule: MISO is 0 in IDLE and ADDR. In DATA, bit 7−k of the read byte is presented after the (8+k)th SCLK fall, for k = 0..7.
- Write commit: in CMPL, if bit15 = 0, the write data goes to the addressed register. Writable addresses are 0x0D, 0x10, 0x11 and 0x14; writes to any other address are ignored.
- Read map:
  - 0x0D, 0x10, 0x11, 0x14: the stored configuration values.
  - 0x0F: `WHO_AM_I`.
  - 0x22/0x23: ptch L/H. 0x24/0x25: roll L/H. 0x26/0x27: yaw L/H.
  - 0x28/0x29: ax L/H. 0x2A/0x2B: ay L/H.
  - Any other address returns 8'h00.
- Sample loading:
  - A `smpl_vld` pulse while in IDLE copies the five inputs into the data registers in the same cycle.
  - A `smpl_vld` pulse outside IDLE captures the inputs into a one-deep pending buffer. The buffer is applied on the first cycle back in IDLE, so no frame ever returns a torn value.
  - A second `smpl_vld` while the buffer is full overwrites the buffer; the newest sample wins.
- INT set: INT asserts the cycle after a sample is applied, but only if `cfg_int1[1]` = 1.
- INT clear: INT clears in CMPL of a completed read of address 0x22.
- INT priority: if a sample is applied in the same cycle as the clear, set wins.
- Reset clears all outputs, the data registers, the pending buffer and the FSM (state IDLE).

## Timing
- Input latency: a pin edge is seen as an event pulse 3 `clk` cycles after the pin changes.
- SCLK high time and SCLK low time must each be ≥ `SCLK_DIV_MIN`/2 `clk` periods.
- MISO latency: MISO is valid ≤ 4 `clk` after the pin-level SCLK fall, well before the next rise.
- Write latency: the `cfg_*` output updates the cycle after CMPL, which is 4 `clk` after the 16th pin-level rise.
- `rst` asserted mid-frame aborts the frame; MISO is 0 on the next cycle. The remainder of that frame is ignored, because the FSM restarts only on a fresh `SS_n` fall.
- Reset values: MISO = 0, INT = 0, all `cfg_*` = 8'h00.

## Test plan
- Start-up writes: master writes 0x0D02, 0x1062, 0x1162, 0x1460 → `cfg_int1` = 02, `cfg_xl` = 62, `cfg_g` = 62, `cfg_ctrl3` = 60; INT stays 0.
- Identity read: read frame 0x8F00 → master receives rd_data[7:0] = 8'h6A, and MISO = 0 for the first 8 bits.
- Full poll: with `cfg_int1` = 02, pulse `smpl_vld` with ptch = 16'h1234, roll = 16'hABCD, yaw = 16'h0F0F, ax = 16'h8001, ay = 16'h7FFE.
  - INT rises the cycle after the pulse.
  - Reads of 0xA2..0xAB return 34, 12, CD, AB, 0F, 0F, 01, 80, FE, 7F.
  - INT falls after the 0xA2 read completes.
- Sample during a frame: issue `smpl_vld` with ptch = 16'h5555 in the middle of a 0xA3 read. That read returns the old high byte, and the next 0xA3 read returns 8'h55.
- Aborted frame: write 0x10FF with `SS_n` raised after 10 bits → `cfg_xl` is unchanged. The following full frame decodes correctly.
- Reset and priority:
  - Assert `rst` mid-read → MISO = 0 and INT = 0.
  - A sample applied in the same cycle as the 0xA2 read's CMPL leaves INT = 1.
